// File: rtl/mdu_if.sv
// Execute-stage <-> multiply/divide scheduler bus: opcode, operands, stall/flush, HI/LO.
interface mdu_if;
  logic        flush_i;
  logic        stall_i;
  logic [3:0]  mduop_i;
  logic [31:0] opr1_i;
  logic [31:0] opr2_i;
  logic        stallreq_o;
  logic        busy_o;
  logic [31:0] res_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output flush_i, stall_i, mduop_i, opr1_i, opr2_i,
    input  stallreq_o, busy_o, res_o, hi_o, lo_o
  );

  modport slave (
    input  flush_i, stall_i, mduop_i, opr1_i, opr2_i,
    output stallreq_o, busy_o, res_o, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler owning HI/LO: 32-cycle restoring divider, multiplier
// iterative by default or single-cycle when MDU_FAST_MUL_EN is defined.
module mdu_sched (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [3:0] OP_MULT = 4'd1, OP_DIVU = 4'd4, OP_DIV = 4'd3;
  localparam logic [3:0] OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;

  state_t      state, state_nxt;
  logic [31:0] hi, lo, a_mag, b_mag, quo;
  logic [32:0] rem;
  logic [4:0]  cnt;
  logic        sa, sb;
  logic        start, is_signed, fin, stallreq;
  logic [31:0] opr1_mag, opr2_mag;
  logic [33:0] rem_sh, diff;
  logic        q_bit;
  logic [32:0] rem_n;
  logic [31:0] quo_n, q_fix, r_fix;
  logic [63:0] prod_n, prod_fix;
`ifndef MDU_FAST_MUL_EN
  logic [63:0] prod;
  logic [32:0] madd;
`endif

  assign start     = (bus.mduop_i >= OP_MULT) && (bus.mduop_i <= OP_DIVU);
  assign is_signed = (bus.mduop_i == OP_MULT) || (bus.mduop_i == OP_DIV);
  assign opr1_mag  = (is_signed && bus.opr1_i[31]) ? -bus.opr1_i : bus.opr1_i;
  assign opr2_mag  = (is_signed && bus.opr2_i[31]) ? -bus.opr2_i : bus.opr2_i;

  // Restoring step: quo doubles as the dividend shift register. A zero divisor
  // naturally yields all-ones quotient and remainder = dividend.
  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {2'b00, b_mag};
  assign q_bit  = ~diff[33];
  assign rem_n  = q_bit ? diff[32:0] : rem_sh[32:0];
  assign quo_n  = {quo[30:0], q_bit};
  assign q_fix  = (sa ^ sb) ? -quo_n : quo_n;
  assign r_fix  = sa ? -rem_n[31:0] : rem_n[31:0];

`ifdef MDU_FAST_MUL_EN
  assign prod_n = {32'd0, a_mag} * {32'd0, b_mag};
`else
  // Shift-add: multiplier sits in the low half and shifts out as the product shifts in.
  assign madd   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, a_mag} : 33'd0);
  assign prod_n = {madd, prod[31:1]};
`endif
  assign prod_fix = (sa ^ sb) ? -prod_n : prod_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (start) begin
        stallreq  = 1'b1;
        state_nxt = (bus.mduop_i < OP_DIV) ? MUL : DIV;
      end
      MUL: begin
        stallreq = 1'b1;
`ifdef MDU_FAST_MUL_EN
        fin = 1'b1;
`else
        fin = (cnt == 5'd31);
`endif
        if (fin) state_nxt = DONE;
      end
      DIV: begin
        stallreq = 1'b1;
        fin      = (cnt == 5'd31);
        if (fin) state_nxt = DONE;
      end
      DONE: if (!bus.stall_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush_i) begin
      state_nxt = IDLE;
      stallreq  = 1'b0;
      fin       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0; lo <= '0; a_mag <= '0; b_mag <= '0; quo <= '0;
      rem <= '0; cnt <= '0; sa <= 1'b0; sb <= 1'b0;
`ifndef MDU_FAST_MUL_EN
      prod <= '0;
`endif
    end else begin
      if (fin) begin
        if (state == DIV) {hi, lo} <= {r_fix, q_fix};
        else              {hi, lo} <= prod_fix;
      end
      case (state)
        IDLE: if (!bus.flush_i) begin
          if (start) begin
            a_mag <= opr1_mag;
            b_mag <= opr2_mag;
            sa    <= is_signed & bus.opr1_i[31];
            sb    <= is_signed & bus.opr2_i[31];
            quo   <= opr1_mag;
            rem   <= '0;
            cnt   <= '0;
`ifndef MDU_FAST_MUL_EN
            prod  <= {32'd0, opr2_mag};
`endif
          end else if (!bus.stall_i && bus.mduop_i == OP_MTHI) begin
            hi <= bus.opr1_i;
          end else if (!bus.stall_i && bus.mduop_i == OP_MTLO) begin
            lo <= bus.opr1_i;
          end
        end
        MUL: begin
          cnt <= cnt + 5'd1;
`ifndef MDU_FAST_MUL_EN
          prod <= prod_n;
`endif
        end
        DIV: begin
          cnt <= cnt + 5'd1;
          rem <= rem_n;
          quo <= quo_n;
        end
        default: ;
      endcase
    end
  end

  assign bus.stallreq_o = stallreq;
  assign bus.busy_o     = (state == MUL) || (state == DIV);
  assign bus.res_o      = (bus.mduop_i == OP_MFHI) ? hi :
                          (bus.mduop_i == OP_MFLO) ? lo : 32'd0;
  assign bus.hi_o       = hi;
  assign bus.lo_o       = lo;
endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: directed vector table, multi-cycle corner sequences, random ops vs model.
module tb_mdu_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  logic [31:0] exp_hi, exp_lo;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  mdu_if bus();
  mdu_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[8];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic; zero divisor gives all-ones / dividend magnitudes.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    logic [31:0] rm, qm;
    logic neg;
    sa = $signed(a);
    sb = $signed(b);
    res = '0;
    case (op)
      4'd1: begin q = sa * sb; res = q; end
      4'd2: res = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          neg = (op == 4'd3) && a[31];
          rm  = neg ? -a : a;
          qm  = 32'hFFFF_FFFF;
          res = {neg ? -rm : rm, neg ? -qm : qm};
        end else if (op == 4'd3) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  // Issue a start op in IDLE; returns with the DUT in DONE and the stall-request cycle count.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    bus.mduop_i = op; bus.opr1_i = a; bus.opr2_i = b;
    lat = 0;
    #2;
    while (bus.stallreq_o && lat < 100) begin
      lat++;
      tick();
      bus.mduop_i = 4'd0;
      #2;
    end
  endtask

  task automatic op_check(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    run_op(op, a, b, lat);
    chk({name, "_lat"}, 64'(lat), 64'((op <= 4'd2) ? MUL_LAT : DIV_LAT));
    chk({name, "_hilo"}, {bus.hi_o, bus.lo_o}, {ehi, elo});
    tick();
    bus.mduop_i = 4'd6;
    #2;
    chk({name, "_mflo"}, 64'(bus.res_o), 64'(elo));
    bus.mduop_i = 4'd0;
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  initial begin
    logic [63:0] m;
    logic [3:0]  op;
    logic [31:0] a, b;
    int lat;

    vecs[0] = '{4'd4, 32'd100,        32'd7,        32'd2,        32'd14};
    vecs[1] = '{4'd3, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2] = '{4'd4, 32'd7,          32'd0,        32'd7,        32'hFFFF_FFFF};
    vecs[3] = '{4'd1, 32'hFFFF_FFFE,  32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[4] = '{4'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    vecs[5] = '{4'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    vecs[6] = '{4'd3, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9, 32'd1};
    vecs[7] = '{4'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0};

    bus.flush_i = 1'b0; bus.stall_i = 1'b0; bus.mduop_i = 4'd0;
    bus.opr1_i = '0; bus.opr2_i = '0;
    tick(); tick();
    chk("rst_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_lo", 64'(bus.lo_o), 64'd0);
    chk("rst_stallreq", 64'(bus.stallreq_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_res", 64'(bus.res_o), 64'd0);
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    tick();

    for (int i = 0; i < 8; i++)
      op_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI then MFHI next cycle; MTLO blocked by stall, then by flush, then accepted.
    bus.mduop_i = 4'd7; bus.opr1_i = 32'h1234;
    tick();
    bus.mduop_i = 4'd5;
    #2 chk("mthi_mfhi", 64'(bus.res_o), 64'h1234);
    exp_hi = 32'h1234;
    bus.mduop_i = 4'd8; bus.opr1_i = 32'hDEAD_BEEF; bus.stall_i = 1'b1;
    tick();
    bus.stall_i = 1'b0; bus.mduop_i = 4'd6;
    #2 chk("mtlo_stalled", 64'(bus.res_o), 64'(exp_lo));
    bus.mduop_i = 4'd8; bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0; bus.mduop_i = 4'd6;
    #2 chk("mtlo_flushed", 64'(bus.lo_o), 64'(exp_lo));
    bus.mduop_i = 4'd8; bus.opr1_i = 32'h5A5A_0001;
    tick();
    bus.mduop_i = 4'd6;
    #2 chk("mtlo_ok", 64'(bus.res_o), 64'h5A5A_0001);
    exp_lo = 32'h5A5A_0001;
    bus.mduop_i = 4'd0;

    // DONE held by stall with a start opcode still present: no restart, no stall request.
    run_op(4'd4, 32'd100, 32'd7, lat);
    chk("done_lat", 64'(lat), 64'(DIV_LAT));
    bus.stall_i = 1'b1; bus.mduop_i = 4'd4;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("done_hold_stallreq%0d", i), 64'(bus.stallreq_o), 64'd0);
      chk($sformatf("done_hold_busy%0d", i), 64'(bus.busy_o), 64'd0);
      tick();
    end
    bus.stall_i = 1'b0; bus.mduop_i = 4'd0;
    tick();
    chk("done_hilo", {bus.hi_o, bus.lo_o}, {32'd2, 32'd14});
    exp_hi = 32'd2; exp_lo = 32'd14;
    // Back in IDLE: start decodes, but a flush in the same cycle wins.
    bus.mduop_i = 4'd4;
    #2 chk("idle_start_stallreq", 64'(bus.stallreq_o), 64'd1);
    bus.flush_i = 1'b1;
    #2 chk("flush_start_stallreq", 64'(bus.stallreq_o), 64'd0);
    tick();
    bus.flush_i = 1'b0; bus.mduop_i = 4'd0;
    #2 chk("flush_start_busy", 64'(bus.busy_o), 64'd0);
    tick();

    // Flush on the final divide iteration: no HI/LO write, IDLE next cycle.
    bus.mduop_i = 4'd4; bus.opr1_i = 32'd1000; bus.opr2_i = 32'd3;
    #2 chk("fl_start_stallreq", 64'(bus.stallreq_o), 64'd1);
    tick();
    bus.mduop_i = 4'd0;
    #2 chk("fl_busy", 64'(bus.busy_o), 64'd1);
    for (int i = 0; i < 31; i++) tick();
    bus.flush_i = 1'b1;
    #2 chk("fl_t32_stallreq", 64'(bus.stallreq_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    #2;
    chk("fl_t33_busy", 64'(bus.busy_o), 64'd0);
    chk("fl_t33_hilo", {bus.hi_o, bus.lo_o}, {exp_hi, exp_lo});
    tick();

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      m = model(op, a, b);
      op_check($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), op, a, b, m[63:32], m[31:0]);
    end

    // Reset in the middle of a divide clears HI/LO and returns to IDLE.
    bus.mduop_i = 4'd3; bus.opr1_i = 32'd12345; bus.opr2_i = 32'hFFFF_FFFB;
    tick();
    bus.mduop_i = 4'd0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("midrst_busy", 64'(bus.busy_o), 64'd0);
    chk("midrst_stallreq", 64'(bus.stallreq_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    op_check("post_rst", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
